wb_commit_stage: RTL and testbench

- Writeback/commit stage of the 16-bit pipelined processor; sits directly downstream of the memory stage.
- Registers the MEM/WB boundary and selects writeback data.
- Drives the register-file write port and produces a single-cycle retire record: PC, instruction, reg write, mem write and halt. This record is the one place the simulation harness and trace logic read commit information from.
- Owns the sticky halted state and, optionally, the cycle and instruction counters.

---
 rtl/wb_commit_stage.sv | 149 ++++++++++++++
 tb/tb_wb_commit_stage.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_commit_stage.sv
// Writeback/commit stage: MEM/WB register, writeback select, retire record, sticky halt.
// Optional cycle/instruction counters are built only when WB_PERF_CNT_EN is defined.
module wb_commit_stage #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  input  logic [DATA_W-1:0] mem_pc,
  input  logic [15:0]       mem_instr,
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] mem_writereg,
  input  logic [1:0]        mem_wbsel,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_memread,
  input  logic              mem_memwrite,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_halt,
  output logic              wb_we,
  output logic [REG_AW-1:0] wb_wreg,
  output logic [DATA_W-1:0] wb_wdata,
  output logic              retire_valid,
  output logic [DATA_W-1:0] retire_pc,
  output logic [15:0]       retire_instr,
  output logic              retire_memread,
  output logic              retire_memwrite,
  output logic [DATA_W-1:0] retire_addr,
  output logic [DATA_W-1:0] retire_mdata,
  output logic              retire_halt,
  output logic              halted,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  inst_count
);

  // Valid-only interface: mem_valid qualifies every mem_* field in the same
  // cycle; there is no ready, the stage accepts one entry every cycle.
  logic              wb_v;
  logic [DATA_W-1:0] wb_pc;
  logic [15:0]       wb_instr;
  logic              wb_regwrite;
  logic [REG_AW-1:0] wb_writereg;
  logic [1:0]        wb_wbsel;
  logic [DATA_W-1:0] wb_alu;
  logic [DATA_W-1:0] wb_rdata;
  logic              wb_memread;
  logic              wb_memwrite;
  logic [DATA_W-1:0] wb_sdata;
  logic              wb_halt;
  logic              halted_q;

  logic              halt_now;
  logic              capture_v;
  logic [DATA_W-1:0] pc_plus2;
  logic [DATA_W-1:0] sel_data;

  assign halt_now  = wb_v & wb_halt;
  // Anything arriving in or after the cycle HALT retires is dropped.
  assign capture_v = mem_valid & ~halted_q & ~halt_now;

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_v        <= 1'b0;
      wb_pc       <= '0;
      wb_instr    <= '0;
      wb_regwrite <= 1'b0;
      wb_writereg <= '0;
      wb_wbsel    <= '0;
      wb_alu      <= '0;
      wb_rdata    <= '0;
      wb_memread  <= 1'b0;
      wb_memwrite <= 1'b0;
      wb_sdata    <= '0;
      wb_halt     <= 1'b0;
    end else begin
      wb_v        <= capture_v;
      wb_pc       <= mem_pc;
      wb_instr    <= mem_instr;
      wb_regwrite <= mem_regwrite;
      wb_writereg <= mem_writereg;
      wb_wbsel    <= mem_wbsel;
      wb_alu      <= mem_alu_result;
      wb_rdata    <= mem_rdata;
      wb_memread  <= mem_memread;
      wb_memwrite <= mem_memwrite;
      wb_sdata    <= mem_wdata;
      wb_halt     <= mem_halt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      halted_q <= 1'b0;
    end else if (halt_now) begin
      halted_q <= 1'b1;
    end
  end

  assign pc_plus2 = wb_pc + DATA_W'(2);

  always_comb begin
    sel_data = wb_alu;
    case (wb_wbsel)
      2'b01:   sel_data = wb_rdata;
      2'b10:   sel_data = pc_plus2;
      default: sel_data = wb_alu;
    endcase
  end

  // HALT suppresses its own register write even if regwrite is set.
  assign wb_we           = wb_v & wb_regwrite & ~wb_halt;
  assign wb_wreg         = wb_writereg;
  assign wb_wdata        = sel_data;
  assign retire_valid    = wb_v;
  assign retire_pc       = wb_pc;
  assign retire_instr    = wb_instr;
  assign retire_memread  = wb_v & wb_memread;
  assign retire_memwrite = wb_v & wb_memwrite;
  assign retire_addr     = wb_alu;
  assign retire_mdata    = wb_sdata;
  assign retire_halt     = halt_now;
  assign halted          = halted_q;

`ifdef WB_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] inst_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q <= '0;
      inst_q  <= '0;
    end else if (!halted_q) begin
      cycle_q <= cycle_q + CNT_W'(1);
      if (wb_v) begin
        inst_q <= inst_q + CNT_W'(1);
      end
    end
  end

  assign cycle_count = cycle_q;
  assign inst_count  = inst_q;
`else
  assign cycle_count = '0;
  assign inst_count  = '0;
`endif

endmodule

// File: tb/tb_wb_commit_stage.sv
// Bench for wb_commit_stage: directed vector table, hand-written halt/reset
// sequences, and randomized traffic against a retire-level reference model.
module tb_wb_commit_stage;

  typedef struct packed {
    logic        valid;
    logic [15:0] pc;
    logic [15:0] instr;
    logic        regwrite;
    logic [2:0]  writereg;
    logic [1:0]  wbsel;
    logic [15:0] alu;
    logic [15:0] rdata;
    logic        memread;
    logic        memwrite;
    logic [15:0] wdata;
    logic        halt;
  } in_t;

  typedef struct packed {
    logic        we;
    logic [2:0]  wreg;
    logic [15:0] wdata;
    logic        rv;
    logic [15:0] rpc;
    logic [15:0] rinstr;
    logic        rmr;
    logic        rmw;
    logic [15:0] raddr;
    logic [15:0] rmdata;
    logic        rhalt;
    logic        halted;
    logic [31:0] cyc;
    logic [31:0] inst;
  } out_t;

  typedef struct {
    in_t         in;
    logic        we;
    logic [2:0]  wreg;
    logic [15:0] wdata;
    logic        rv;
    logic        rmr;
    logic        rmw;
    logic [15:0] raddr;
    logic [15:0] rmdata;
    logic        rhalt;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  in_t cur_in = '0;

  logic        wb_we, retire_valid, retire_memread, retire_memwrite, retire_halt, halted;
  logic [2:0]  wb_wreg;
  logic [15:0] wb_wdata, retire_pc, retire_instr, retire_addr, retire_mdata;
  logic [31:0] cycle_count, inst_count;

  wb_commit_stage dut (
    .clk(clk), .rst(rst),
    .mem_valid(cur_in.valid), .mem_pc(cur_in.pc), .mem_instr(cur_in.instr),
    .mem_regwrite(cur_in.regwrite), .mem_writereg(cur_in.writereg),
    .mem_wbsel(cur_in.wbsel), .mem_alu_result(cur_in.alu), .mem_rdata(cur_in.rdata),
    .mem_memread(cur_in.memread), .mem_memwrite(cur_in.memwrite),
    .mem_wdata(cur_in.wdata), .mem_halt(cur_in.halt),
    .wb_we(wb_we), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .retire_valid(retire_valid), .retire_pc(retire_pc), .retire_instr(retire_instr),
    .retire_memread(retire_memread), .retire_memwrite(retire_memwrite),
    .retire_addr(retire_addr), .retire_mdata(retire_mdata),
    .retire_halt(retire_halt), .halted(halted),
    .cycle_count(cycle_count), .inst_count(inst_count)
  );

  int checks = 0;
  int errors = 0;

  // reference model: what is retiring now, whether the machine has halted
  logic        m_halted = 1'b0;
  logic        m_rv = 1'b0;
  in_t         m_rec = '0;
  logic [31:0] m_cyc = 0;
  logic [31:0] m_inst = 0;
  out_t        exp_q[$];
  vec_t        vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  function automatic in_t make_in(input logic v, input logic [15:0] pc, input logic [15:0] instr,
                                  input logic rw, input logic [2:0] wr, input logic [1:0] sel,
                                  input logic [15:0] alu, input logic [15:0] rd, input logic mr,
                                  input logic mw, input logic [15:0] wd, input logic h);
    in_t r;
    r.valid = v; r.pc = pc; r.instr = instr; r.regwrite = rw; r.writereg = wr;
    r.wbsel = sel; r.alu = alu; r.rdata = rd; r.memread = mr; r.memwrite = mw;
    r.wdata = wd; r.halt = h;
    return r;
  endfunction

  function automatic vec_t make_vec(input in_t in, input logic we, input logic [2:0] wreg,
                                    input logic [15:0] wdata, input logic rv, input logic rmr,
                                    input logic rmw, input logic [15:0] raddr,
                                    input logic [15:0] rmdata, input logic rhalt);
    vec_t v;
    v.in = in; v.we = we; v.wreg = wreg; v.wdata = wdata; v.rv = rv; v.rmr = rmr;
    v.rmw = rmw; v.raddr = raddr; v.rmdata = rmdata; v.rhalt = rhalt;
    return v;
  endfunction

  function automatic out_t predict();
    out_t e;
    int unsigned link;
    link = (int'(m_rec.pc) + 2) % 65536;
    e.we     = m_rv && m_rec.regwrite && !m_rec.halt;
    e.wreg   = m_rec.writereg;
    if (m_rec.wbsel == 2'b01)      e.wdata = m_rec.rdata;
    else if (m_rec.wbsel == 2'b10) e.wdata = link[15:0];
    else                           e.wdata = m_rec.alu;
    e.rv     = m_rv;
    e.rpc    = m_rec.pc;
    e.rinstr = m_rec.instr;
    e.rmr    = m_rv && m_rec.memread;
    e.rmw    = m_rv && m_rec.memwrite;
    e.raddr  = m_rec.alu;
    e.rmdata = m_rec.wdata;
    e.rhalt  = m_rv && m_rec.halt;
    e.halted = m_halted;
`ifdef WB_PERF_CNT_EN
    e.cyc    = m_cyc;
    e.inst   = m_inst;
`else
    e.cyc    = 0;
    e.inst   = 0;
`endif
    return e;
  endfunction

  task automatic check_model();
    out_t e;
    e = exp_q.pop_front();
    chk("mdl.wb_we", wb_we, e.we);
    chk("mdl.wb_wreg", wb_wreg, e.wreg);
    chk("mdl.wb_wdata", wb_wdata, e.wdata);
    chk("mdl.retire_valid", retire_valid, e.rv);
    chk("mdl.retire_pc", retire_pc, e.rpc);
    chk("mdl.retire_instr", retire_instr, e.rinstr);
    chk("mdl.retire_memread", retire_memread, e.rmr);
    chk("mdl.retire_memwrite", retire_memwrite, e.rmw);
    chk("mdl.retire_addr", retire_addr, e.raddr);
    chk("mdl.retire_mdata", retire_mdata, e.rmdata);
    chk("mdl.retire_halt", retire_halt, e.rhalt);
    chk("mdl.halted", halted, e.halted);
    chk("mdl.cycle_count", cycle_count, e.cyc);
    chk("mdl.inst_count", inst_count, e.inst);
  endtask

  // Advance the model across one clock edge, then let the DUT take the same edge.
  task automatic tick();
    if (rst) begin
      m_halted = 1'b0; m_rv = 1'b0; m_rec = '0; m_cyc = 0; m_inst = 0;
    end else begin
      if (!m_halted) begin
        m_cyc++;
        if (m_rv) m_inst++;
      end
      if (m_rv && m_rec.halt) m_halted = 1'b1;
      m_rv  = cur_in.valid && !m_halted;
      m_rec = cur_in;
    end
    exp_q.push_back(predict());
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".we"}, wb_we, 0);
    chk({tag, ".wreg"}, wb_wreg, 0);
    chk({tag, ".wdata"}, wb_wdata, 0);
    chk({tag, ".rv"}, retire_valid, 0);
    chk({tag, ".pc"}, retire_pc, 0);
    chk({tag, ".instr"}, retire_instr, 0);
    chk({tag, ".addr"}, retire_addr, 0);
    chk({tag, ".mdata"}, retire_mdata, 0);
    chk({tag, ".rhalt"}, retire_halt, 0);
    chk({tag, ".halted"}, halted, 0);
    chk({tag, ".cyc"}, cycle_count, 0);
    chk({tag, ".inst"}, inst_count, 0);
  endtask

  in_t add_r1;
  logic [31:0] frozen_cyc, frozen_inst;

  initial begin
    vecs[0] = make_vec(make_in(1, 16'h0010, 16'h0C4A, 1, 3'd3, 2'b00, 16'h1234, 16'h0000, 0, 0, 16'h0000, 0),
                       1, 3'd3, 16'h1234, 1, 0, 0, 16'h1234, 16'h0000, 0);
    vecs[1] = make_vec(make_in(1, 16'h0012, 16'h8A40, 1, 3'd2, 2'b01, 16'h0040, 16'hBEEF, 1, 0, 16'h0000, 0),
                       1, 3'd2, 16'hBEEF, 1, 1, 0, 16'h0040, 16'h0000, 0);
    vecs[2] = make_vec(make_in(1, 16'hFFFE, 16'hC7F0, 1, 3'd7, 2'b10, 16'h3333, 16'h4444, 0, 0, 16'h0000, 0),
                       1, 3'd7, 16'h0000, 1, 0, 0, 16'h3333, 16'h0000, 0);
    vecs[3] = make_vec(make_in(1, 16'h0014, 16'hA410, 0, 3'd1, 2'b00, 16'h0010, 16'h0000, 0, 1, 16'h00AA, 0),
                       0, 3'd1, 16'h0010, 1, 0, 1, 16'h0010, 16'h00AA, 0);
    vecs[4] = make_vec(make_in(0, 16'h0016, 16'h0000, 1, 3'd4, 2'b11, 16'h5555, 16'h6666, 1, 1, 16'h7777, 1),
                       0, 3'd4, 16'h5555, 0, 0, 0, 16'h5555, 16'h7777, 0);
    vecs[5] = make_vec(make_in(1, 16'h0018, 16'h1111, 1, 3'd5, 2'b11, 16'h7777, 16'h1111, 0, 0, 16'h0000, 0),
                       1, 3'd5, 16'h7777, 1, 0, 0, 16'h7777, 16'h0000, 0);
    vecs[6] = make_vec(make_in(1, 16'h0100, 16'hC000, 1, 3'd6, 2'b10, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0),
                       1, 3'd6, 16'h0102, 1, 0, 0, 16'h0000, 16'h0000, 0);
    add_r1 = make_in(1, 16'h0202, 16'h0241, 1, 3'd1, 2'b00, 16'h1111, 16'h0000, 0, 0, 16'h0000, 0);

    // reset state
    rst = 1'b1;
    cur_in = vecs[0].in;
    tick();
    chk_all_zero("reset");
    tick();
    rst = 1'b0;
    cur_in = '0;
    tick();

    // directed vector table
    for (int i = 0; i < 7; i++) begin
      cur_in = vecs[i].in;
      tick();
      chk($sformatf("vec%0d.we", i), wb_we, vecs[i].we);
      chk($sformatf("vec%0d.wreg", i), wb_wreg, vecs[i].wreg);
      chk($sformatf("vec%0d.wdata", i), wb_wdata, vecs[i].wdata);
      chk($sformatf("vec%0d.rv", i), retire_valid, vecs[i].rv);
      chk($sformatf("vec%0d.pc", i), retire_pc, vecs[i].in.pc);
      chk($sformatf("vec%0d.instr", i), retire_instr, vecs[i].in.instr);
      chk($sformatf("vec%0d.memread", i), retire_memread, vecs[i].rmr);
      chk($sformatf("vec%0d.memwrite", i), retire_memwrite, vecs[i].rmw);
      chk($sformatf("vec%0d.addr", i), retire_addr, vecs[i].raddr);
      chk($sformatf("vec%0d.mdata", i), retire_mdata, vecs[i].rmdata);
      chk($sformatf("vec%0d.rhalt", i), retire_halt, vecs[i].rhalt);
      chk($sformatf("vec%0d.halted", i), halted, 0);
    end
    cur_in = '0;
    tick();
    chk("bubble.rv", retire_valid, 0);
    chk("bubble.we", wb_we, 0);

    // HALT with regwrite, then ADDs that must never retire
    cur_in = make_in(1, 16'h0200, 16'hF000, 1, 3'd5, 2'b00, 16'h9999, 16'h0000, 0, 0, 16'h0000, 1);
    tick();
    chk("halt.rhalt", retire_halt, 1);
    chk("halt.rv", retire_valid, 1);
    chk("halt.we", wb_we, 0);
    chk("halt.halted_early", halted, 0);
    cur_in = add_r1;
    tick();
    chk("halt.after_rv", retire_valid, 0);
    chk("halt.after_we", wb_we, 0);
    chk("halt.halted", halted, 1);
    frozen_cyc = m_cyc;
    frozen_inst = m_inst;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("halt.stuck_rv", retire_valid, 0);
      chk("halt.sticky", halted, 1);
    end
`ifdef WB_PERF_CNT_EN
    chk("halt.cyc_frozen", cycle_count, frozen_cyc);
    chk("halt.inst_frozen", inst_count, frozen_inst);
`endif

    // reset clears halted; then reset discards an instruction sitting in WB
    rst = 1'b1;
    cur_in = add_r1;
    tick();
    chk_all_zero("rst_halt");
    rst = 1'b0;
    cur_in = make_in(1, 16'h0300, 16'h0904, 1, 3'd4, 2'b00, 16'h4444, 16'h0000, 0, 0, 16'h0000, 0);
    tick();
    chk("post_rst.rv", retire_valid, 1);
    chk("post_rst.wdata", wb_wdata, 16'h4444);
    cur_in = make_in(1, 16'h0302, 16'h0D06, 1, 3'd6, 2'b00, 16'h6666, 16'h0000, 0, 1, 16'h0101, 0);
    tick();
    chk("inflight.rv", retire_valid, 1);
    rst = 1'b1;
    cur_in = '0;
    tick();
    chk_all_zero("rst_inflight");
    rst = 1'b0;
    tick();
    chk("rst_inflight.after_rv", retire_valid, 0);

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 39) == 0);
      cur_in.valid    = ($urandom_range(0, 9) < 8);
      cur_in.pc       = ($urandom_range(0, 9) == 0) ? 16'hFFFE : (16'($urandom) & 16'hFFFE);
      cur_in.instr    = 16'($urandom);
      cur_in.regwrite = 1'($urandom);
      cur_in.writereg = 3'($urandom);
      cur_in.wbsel    = 2'($urandom);
      cur_in.alu      = 16'($urandom);
      cur_in.rdata    = 16'($urandom);
      cur_in.memread  = 1'($urandom);
      cur_in.memwrite = 1'($urandom);
      cur_in.wdata    = 16'($urandom);
      cur_in.halt     = ($urandom_range(0, 49) == 0);
      tick();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
